imm_ext_arbiter: RTL and testbench

- Time-shares one 16-to-32-bit immediate extension datapath between NREQ requesters, e.g. the decode stage and the branch-target unit.
- Round-robin arbitration with a valid/ready handshake on every requester port.
- One registered output slot with backpressure; the result is tagged with the winning requester's index.
- Sits between the instruction-field decode logic and the ALU operand / branch-target muxes.

---
 rtl/ext_pkg.sv | 12 +
 rtl/imm_ext_unit.sv | 22 ++
 rtl/imm_ext_arbiter.sv | 134 +++++++++++++
 tb/tb_imm_ext_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Immediate-extension mode encoding shared by the decoder and the
// extension arbiter.
package ext_pkg;

    typedef enum logic [1:0] {
        EXT_SEXT     = 2'b00,  // sign-extend 16 -> 32
        EXT_ZEXT     = 2'b01,  // zero-extend 16 -> 32
        EXT_SEXT_SH2 = 2'b10,  // sign-extend, then word-offset shift by 2
        EXT_UPPER    = 2'b11   // place immediate in the upper half
    } ext_mode_t;

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational 16-to-32-bit immediate extender.
module imm_ext_unit
    import ext_pkg::*;
(
    input  logic [15:0] imm,
    input  ext_mode_t   mode,
    output logic [31:0] result
);

    // Select the extension form for the requested mode.
    always_comb begin
        result = {{16{imm[15]}}, imm};
        case (mode)
            EXT_SEXT:     result = {{16{imm[15]}}, imm};
            EXT_ZEXT:     result = {16'h0000, imm};
            EXT_SEXT_SH2: result = {{14{imm[15]}}, imm, 2'b00};
            EXT_UPPER:    result = {imm, 16'h0000};
            default:      result = {{16{imm[15]}}, imm};
        endcase
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter time-sharing one immediate extender between NREQ
// requesters, with a single registered output slot and backpressure.
module imm_ext_arbiter
    import ext_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int ID_W  = 1,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_imm,
    input  logic [2*NREQ-1:0]    req_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [ID_W-1:0]      out_id,
    output logic [CNT_W-1:0]     xfer_count
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t       state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;

    logic              can_accept;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_idx;
    logic [15:0]       sel_imm;
    ext_mode_t         sel_mode;
    logic [31:0]       ext_result;

    // Requester index k positions after base, wrapping modulo NREQ
    // (base is always < NREQ, so one subtraction suffices).
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[ID_W-1:0];
    endfunction

    // Round-robin pick: first valid requester at or after rr_ptr. The grant
    // depends only on valids, slot state and out_ready, never on the payload.
    always_comb begin
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        can_accept = (state_q == SLOT_EMPTY) || out_ready;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req_valid[rr_index(rr_ptr_q, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_index(rr_ptr_q, k);
            end
        end
        gnt_any = gnt_any && can_accept && rst_n;
    end

    // One-hot accept back to the winning requester.
    always_comb begin
        req_ready = '0;
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    // Grant mux feeding the single shared extender.
    always_comb begin
        sel_imm  = req_imm[int'(gnt_idx)*16 +: 16];
        sel_mode = ext_mode_t'(req_mode[int'(gnt_idx)*2 +: 2]);
    end

    imm_ext_unit u_ext (
        .imm    (sel_imm),
        .mode   (sel_mode),
        .result (ext_result)
    );

    // Slot FSM next state, output register load, pointer advance and
    // saturating handshake count.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        rr_ptr_d     = rr_ptr_q;
        xfer_count_d = xfer_count_q;

        if (state_q == SLOT_FULL && out_ready && xfer_count_q != '1)
            xfer_count_d = xfer_count_q + CNT_W'(1);

        if (gnt_any) begin
            out_data_d = ext_result;
            out_id_d   = gnt_idx;
            rr_ptr_d   = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end

        case (state_q)
            SLOT_EMPTY: if (gnt_any) state_d = SLOT_FULL;
            SLOT_FULL: begin
                // Drain-and-refill keeps the slot full with no bubble.
                if (gnt_any)        state_d = SLOT_FULL;
                else if (out_ready) state_d = SLOT_EMPTY;
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    // State register; reset discards any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SLOT_EMPTY;
            out_data_q   <= '0;
            out_id_q     <= '0;
            rr_ptr_q     <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            rr_ptr_q     <= rr_ptr_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign out_valid  = (state_q == SLOT_FULL);
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench for imm_ext_arbiter (NREQ=3 to exercise non-power-of-2
// wrap, CNT_W=4 to reach counter saturation quickly).
module tb_imm_ext_arbiter;

    localparam int NREQ  = 3;
    localparam int ID_W  = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] id;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][15:0]      req_imm;
    logic [NREQ-1:0][1:0]       req_mode;
    logic                       out_valid;
    logic                       out_ready;
    logic [31:0]                out_data;
    logic [ID_W-1:0]            out_id;
    logic [CNT_W-1:0]           xfer_count;

    exp_t q[$];
    int   m_ptr, m_cnt, last_gnt;
    logic m_full;
    int   n_tests = 0;
    int   n_fail  = 0;

    imm_ext_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_imm    (req_imm),
        .req_mode   (req_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension written from the arithmetic meaning of each mode.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        int s;
        s = $signed(imm);
        case (mode)
            2'd0:    return s;
            2'd1:    return {16'h0000, imm};
            2'd2:    return s * 4;
            default: return 32'(imm) << 16;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_full   = 1'b0;
        m_ptr    = 0;
        m_cnt    = 0;
        last_gnt = -1;
    endtask

    // One clock: check the combinational grant and slot state against the
    // model at the falling edge, advance the model, return just after the
    // next rising edge so the caller can drive new inputs.
    task automatic tick();
        int g;
        logic [NREQ-1:0] exp_rdy;
        exp_t e;
        @(negedge clk);
        g = -1;
        if (!m_full || out_ready) begin
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
        if (m_full && out_ready && m_cnt < CMAX) m_cnt++;
        if (g >= 0) begin
            e.data = ref_ext(req_imm[g], req_mode[g]);
            e.id   = g;
            q.push_back(e);
            m_ptr  = (g + 1) % NREQ;
            m_full = 1'b1;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
        last_gnt = g;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: the held result must match the oldest expected entry
    // every cycle it is presented; it retires on the handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'h0);
            end else begin
                chk("out_data", out_data, q[0].data);
                chk("out_id", 32'(out_id), q[0].id);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    logic [31:0] mode_const [4];

    initial begin
        mode_const[0] = 32'hFFFF8004;
        mode_const[1] = 32'h00008004;
        mode_const[2] = 32'hFFFE0010;
        mode_const[3] = 32'h80040000;

        req_valid = '0;
        req_imm   = '0;
        req_mode  = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_xfer_count", 32'(xfer_count), 32'h0);
        rst_n = 1'b1;

        // Mode coverage on requester 0, back to back.
        for (int m = 0; m < 4; m++) begin
            req_valid   = 3'b001;
            req_imm[0]  = 16'h8004;
            req_mode[0] = 2'(m);
            tick();
            chk("mode_const", out_data, mode_const[m]);
        end
        req_valid = '0;
        tick();

        // Reset while the slot is full and stalled.
        req_valid   = 3'b001;
        req_imm[0]  = 16'h1234;
        req_mode[0] = 2'd1;
        out_ready   = 1'b0;
        tick();
        req_valid = 3'b011;
        rst_n     = 1'b0;
        #1;
        chk("rstmid_out_valid", 32'(out_valid), 32'h0);
        chk("rstmid_out_data", out_data, 32'h0);
        chk("rstmid_out_id", 32'(out_id), 32'h0);
        chk("rstmid_xfer_count", 32'(xfer_count), 32'h0);
        chk("rstmid_req_ready", 32'(req_ready), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Fairness: 0 and 1 both valid for six grants.
        req_imm[0] = 16'h00A5; req_mode[0] = 2'd0;
        req_imm[1] = 16'hF00F; req_mode[1] = 2'd2;
        repeat (6) tick();

        // Backpressure with requester 1 waiting, then drain-and-refill.
        req_valid  = 3'b010;
        req_imm[1] = 16'h7FFF; req_mode[1] = 2'd3;
        out_ready  = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        req_valid = '0;

        // Idle: pointer must not move, then both valid picks requester 0.
        repeat (5) tick();
        req_valid = 3'b011;
        tick();
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        tick();

        // Saturation of the completed-transfer counter.
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid  = 3'b001;
        req_imm[0] = 16'h0001; req_mode[0] = 2'd1;
        repeat (21) tick();
        req_valid = '0;
        repeat (2) tick();
        chk("sat_count", 32'(xfer_count), 32'(CMAX));
        tick();

        // Randomised traffic; pending requesters keep their payload.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_gnt == i) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_imm[i]   = 16'($urandom);
                    req_mode[i]  = 2'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        req_valid = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("drain_empty", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
